// File: rtl/spi_peripheral_multi.sv
// SPI peripheral with selectable mode, word width, multi-word frames and a one-deep TX holding register.
// Define SPI_PERIPH_FRAME_STATS_EN to add the frame_done / frame_words statistics outputs.
module spi_peripheral_multi #(
  parameter int                WORD_W    = 32,
  parameter bit                CPOL      = 1'b0,
  parameter bit                CPHA      = 1'b0,
  parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
  input  logic              fastclk,
  input  logic              rst,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              SSEL,
  output logic              MISO,
  output logic [WORD_W-1:0] rcvd_word,
  output logic              rcvd_word_valid,
  input  logic [WORD_W-1:0] send_word,
  input  logic              send_valid,
  output logic              send_ready,
  output logic              busy
`ifdef SPI_PERIPH_FRAME_STATS_EN
  ,
  output logic              frame_done,
  output logic [15:0]       frame_words
`endif
);

  localparam int              CNT_W       = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(WORD_W - 1);
  localparam bit              SAMPLE_RISE = (CPOL == CPHA);

  logic [2:0]        sck_s;
  logic [2:0]        ssel_s;
  logic [1:0]        mosi_s;
  logic              settle;
  logic              seen_idle;
  logic              active;
  logic              first_word;
  logic              rx_done;
  logic [CNT_W-1:0]  bitcnt;
  logic [WORD_W-1:0] rx_sr;
  logic [WORD_W-1:0] tx_sr;
  logic [WORD_W-1:0] hold;
  logic              hold_full;

  logic sck_rise;
  logic sck_fall;
  logic sample_edge;
  logic shift_edge;
  logic ssel_fall;
  logic ssel_rise;
  logic reload;
  logic accept;

  assign sck_rise    = sck_s[1] & ~sck_s[2];
  assign sck_fall    = ~sck_s[1] & sck_s[2];
  assign sample_edge = active & (SAMPLE_RISE ? sck_rise : sck_fall);
  assign shift_edge  = active & (SAMPLE_RISE ? sck_fall : sck_rise);
  // A select falling edge only counts once SSEL has been seen idle since reset,
  // so a frame already in progress when reset released is ignored.
  assign ssel_fall   = seen_idle & ~active & ssel_s[2] & ~ssel_s[1];
  assign ssel_rise   = active & ssel_s[1];
  assign reload      = ssel_fall | (shift_edge & (bitcnt == '0) & ~first_word);
  assign accept      = send_valid & ~hold_full;

  assign send_ready  = ~hold_full;
  assign busy        = active;
  assign MISO        = active & tx_sr[WORD_W-1];

  // Input synchronisers
  always_ff @(posedge fastclk) begin
    if (rst) begin
      sck_s  <= {3{CPOL}};
      ssel_s <= 3'b111;
      mosi_s <= '0;
    end else begin
      sck_s  <= {sck_s[1:0], SCK};
      ssel_s <= {ssel_s[1:0], SSEL};
      mosi_s <= {mosi_s[0], MOSI};
    end
  end

  // Frame control and bit counting
  always_ff @(posedge fastclk) begin
    if (rst) begin
      settle          <= 1'b0;
      seen_idle       <= 1'b0;
      active          <= 1'b0;
      first_word      <= 1'b0;
      bitcnt          <= '0;
      rx_done         <= 1'b0;
      rcvd_word_valid <= 1'b0;
    end else begin
      settle          <= 1'b1;
      seen_idle       <= seen_idle | (settle & ssel_s[0]);
      rx_done         <= sample_edge & (bitcnt == LAST_BIT);
      rcvd_word_valid <= rx_done;
      if (ssel_fall)
        active <= 1'b1;
      else if (ssel_rise)
        active <= 1'b0;
      if (ssel_fall)
        first_word <= 1'b1;
      else if (sample_edge)
        first_word <= 1'b0;
      if (!active)
        bitcnt <= '0;
      else if (sample_edge)
        bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + 1'b1;
    end
  end

  // Shift registers, received word and TX holding register
  always_ff @(posedge fastclk) begin
    if (rst) begin
      rx_sr     <= '0;
      tx_sr     <= '0;
      rcvd_word <= '0;
      hold_full <= 1'b0;
    end else begin
      if (sample_edge)
        rx_sr <= {rx_sr[WORD_W-2:0], mosi_s[1]};
      if (rx_done)
        rcvd_word <= rx_sr;
      if (reload)
        tx_sr <= hold_full ? hold : IDLE_WORD;
      else if (shift_edge && (bitcnt != '0))
        tx_sr <= tx_sr << 1;
      // accept implies the holding register was empty, so it never collides with a reload that drains it
      if (reload && hold_full)
        hold_full <= 1'b0;
      else if (accept)
        hold_full <= 1'b1;
    end
  end

  always_ff @(posedge fastclk) begin
    if (accept)
      hold <= send_word;
  end

`ifdef SPI_PERIPH_FRAME_STATS_EN
  // Per-frame statistics
  always_ff @(posedge fastclk) begin
    if (rst) begin
      frame_done  <= 1'b0;
      frame_words <= '0;
    end else begin
      frame_done <= ssel_rise;
      if (ssel_fall)
        frame_words <= '0;
      else if (rx_done && (frame_words != 16'hFFFF))
        frame_words <= frame_words + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_peripheral_multi.sv
// Randomised bench for spi_peripheral_multi: three instances (mode 0/32b, mode 3/32b, mode 1/8b)
// driven by a bit-level SPI master and checked against a word-level holding-register model.
module tb_spi_peripheral_multi;

  localparam int H = 6;

  logic fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  logic        rst;
  logic [2:0]  sck, ssel, mosi, svalid;
  logic [31:0] sw0, sw1;
  logic [7:0]  sw2;
  wire  [2:0]  miso, rv, rdy, bsy;
  wire  [31:0] rw0, rw1;
  wire  [7:0]  rw2;
`ifdef SPI_PERIPH_FRAME_STATS_EN
  wire  [2:0]  fdone;
  wire  [15:0] fw0, fw1, fw2;
`endif

  spi_peripheral_multi #(.WORD_W(32), .CPOL(1'b0), .CPHA(1'b0), .IDLE_WORD(32'h0)) u_m0 (
    .fastclk(fastclk), .rst(rst), .SCK(sck[0]), .MOSI(mosi[0]), .SSEL(ssel[0]), .MISO(miso[0]),
    .rcvd_word(rw0), .rcvd_word_valid(rv[0]), .send_word(sw0), .send_valid(svalid[0]),
    .send_ready(rdy[0]), .busy(bsy[0])
`ifdef SPI_PERIPH_FRAME_STATS_EN
    , .frame_done(fdone[0]), .frame_words(fw0)
`endif
  );

  spi_peripheral_multi #(.WORD_W(32), .CPOL(1'b1), .CPHA(1'b1), .IDLE_WORD(32'h0)) u_m3 (
    .fastclk(fastclk), .rst(rst), .SCK(sck[1]), .MOSI(mosi[1]), .SSEL(ssel[1]), .MISO(miso[1]),
    .rcvd_word(rw1), .rcvd_word_valid(rv[1]), .send_word(sw1), .send_valid(svalid[1]),
    .send_ready(rdy[1]), .busy(bsy[1])
`ifdef SPI_PERIPH_FRAME_STATS_EN
    , .frame_done(fdone[1]), .frame_words(fw1)
`endif
  );

  spi_peripheral_multi #(.WORD_W(8), .CPOL(1'b0), .CPHA(1'b1), .IDLE_WORD(8'h0)) u_m1 (
    .fastclk(fastclk), .rst(rst), .SCK(sck[2]), .MOSI(mosi[2]), .SSEL(ssel[2]), .MISO(miso[2]),
    .rcvd_word(rw2), .rcvd_word_valid(rv[2]), .send_word(sw2), .send_valid(svalid[2]),
    .send_ready(rdy[2]), .busy(bsy[2])
`ifdef SPI_PERIPH_FRAME_STATS_EN
    , .frame_done(fdone[2]), .frame_words(fw2)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Received-word log, one queue per instance
  logic [63:0] rxq0[$], rxq1[$], rxq2[$];
  int fdone_cnt[3];
  initial for (int i = 0; i < 3; i++) fdone_cnt[i] = 0;

  always @(negedge fastclk) begin
    if (rv[0]) rxq0.push_back({32'h0, rw0});
    if (rv[1]) rxq1.push_back({32'h0, rw1});
    if (rv[2]) rxq2.push_back({56'h0, rw2});
`ifdef SPI_PERIPH_FRAME_STATS_EN
    for (int i = 0; i < 3; i++) if (fdone[i]) fdone_cnt[i] <= fdone_cnt[i] + 1;
`endif
  end

  function automatic int rx_size(input int idx);
    case (idx)
      0: return rxq0.size();
      1: return rxq1.size();
      default: return rxq2.size();
    endcase
  endfunction

  task automatic rx_pop(input int idx, output logic [63:0] w);
    case (idx)
      0: w = rxq0.pop_front();
      1: w = rxq1.pop_front();
      default: w = rxq2.pop_front();
    endcase
  endtask

  function automatic logic [63:0] rw(input int idx);
    case (idx)
      0: return {32'h0, rw0};
      1: return {32'h0, rw1};
      default: return {56'h0, rw2};
    endcase
  endfunction

`ifdef SPI_PERIPH_FRAME_STATS_EN
  function automatic logic [63:0] fw(input int idx);
    case (idx)
      0: return {48'h0, fw0};
      1: return {48'h0, fw1};
      default: return {48'h0, fw2};
    endcase
  endfunction
`endif

  function automatic int wid(input int idx);
    return (idx == 2) ? 8 : 32;
  endfunction

  function automatic logic [63:0] mask(input int idx);
    return (idx == 2) ? 64'hFF : 64'hFFFF_FFFF;
  endfunction

  // Holding-register model: at most one pending word; a reload drains it or yields the idle word (0)
  logic [63:0] m_hold[3];
  bit          m_full[3];
  logic [63:0] last_rx[3];

  task automatic m_reload(input int idx, output logic [63:0] w);
    if (m_full[idx]) begin
      w = m_hold[idx];
      m_full[idx] = 1'b0;
    end else begin
      w = '0;
    end
  endtask

  task automatic push(input int idx, input logic [63:0] w);
    int  t;
    logic ok;
    @(negedge fastclk);
    case (idx)
      0: sw0 = w[31:0];
      1: sw1 = w[31:0];
      default: sw2 = w[7:0];
    endcase
    svalid[idx] = 1'b1;
    t = 0;
    ok = 1'b0;
    while (t < 50) begin
      @(posedge fastclk);
      ok = rdy[idx];
      if (ok) break;
      t++;
    end
    #1 svalid[idx] = 1'b0;
    check($sformatf("d%0d_push_ready", idx), {63'h0, ok}, 64'h1);
    m_hold[idx] = w & mask(idx);
    m_full[idx] = 1'b1;
    @(negedge fastclk);
    check($sformatf("d%0d_ready_low", idx), {63'h0, rdy[idx]}, 64'h0);
  endtask

  logic [63:0] tx_w[8], rf_w[8];
  bit          rf_en[8];

  task automatic clear_plan();
    for (int k = 0; k < 8; k++) begin
      rf_en[k] = 1'b0;
      rf_w[k]  = '0;
    end
  endtask

  task automatic run_frame(input int idx, input int nw, input int abort_bits, input bit do_rst);
    int          w, nbits, done_words, n, fd0;
    bit          pha, pol, aborted;
    logic [63:0] exp_m[9];
    logic [63:0] cap, m, got;
    w = wid(idx); pha = (idx != 0); pol = (idx == 1); m = mask(idx);
    nbits = 0; aborted = 1'b0; done_words = 0; fd0 = fdone_cnt[idx];
    @(negedge fastclk);
    ssel[idx] = 1'b0;
    m_reload(idx, exp_m[0]);
    repeat (8) @(negedge fastclk);
    check($sformatf("d%0d_busy_on", idx), {63'h0, bsy[idx]}, 64'h1);
    for (int k = 0; k < nw && !aborted; k++) begin
      cap = '0;
      for (int b = 0; b < w && !aborted; b++) begin
        if (!pha) begin
          mosi[idx] = tx_w[k][w-1-b];
          repeat (H) @(negedge fastclk);
          sck[idx] = ~pol;
          cap = {cap[62:0], miso[idx]};
          repeat (H) @(negedge fastclk);
          sck[idx] = pol;
        end else begin
          sck[idx]  = ~pol;
          mosi[idx] = tx_w[k][w-1-b];
          repeat (H) @(negedge fastclk);
          sck[idx] = pol;
          cap = {cap[62:0], miso[idx]};
          repeat (H) @(negedge fastclk);
        end
        if (b == 1 && rf_en[k]) push(idx, rf_w[k]);
        nbits++;
        if (nbits == abort_bits) aborted = 1'b1;
      end
      if (!aborted) begin
        check($sformatf("d%0d_miso_w%0d", idx, k), cap & m, exp_m[k] & m);
        done_words++;
        if (!pha || k < nw - 1) m_reload(idx, exp_m[k+1]);
      end
    end
    repeat (H) @(negedge fastclk);
    if (do_rst) begin
      rst = 1'b1;
      @(posedge fastclk);
      #1 rst = 1'b0;
      check($sformatf("d%0d_rst_miso", idx), {63'h0, miso[idx]}, 64'h0);
      check($sformatf("d%0d_rst_rword", idx), rw(idx), 64'h0);
      check($sformatf("d%0d_rst_valid", idx), {63'h0, rv[idx]}, 64'h0);
      check($sformatf("d%0d_rst_ready", idx), {63'h0, rdy[idx]}, 64'h1);
      check($sformatf("d%0d_rst_busy", idx), {63'h0, bsy[idx]}, 64'h0);
      for (int i = 0; i < 3; i++) begin
        m_full[i] = 1'b0;
        last_rx[i] = '0;
      end
      done_words = 0;
      repeat (10) @(negedge fastclk);
      check($sformatf("d%0d_rst_stay_idle", idx), {62'h0, bsy[idx], miso[idx]}, 64'h0);
    end
    ssel[idx] = 1'b1;
    repeat (12) @(negedge fastclk);
    check($sformatf("d%0d_busy_off", idx), {63'h0, bsy[idx]}, 64'h0);
    n = rx_size(idx);
    check($sformatf("d%0d_pulses", idx), 64'(n), 64'(done_words));
    for (int j = 0; j < n; j++) begin
      rx_pop(idx, got);
      if (j < 8) begin
        check($sformatf("d%0d_rx_w%0d", idx, j), got, tx_w[j] & m);
        last_rx[idx] = tx_w[j] & m;
      end
    end
    check($sformatf("d%0d_rword_held", idx), rw(idx), last_rx[idx]);
`ifdef SPI_PERIPH_FRAME_STATS_EN
    check($sformatf("d%0d_frame_words", idx), fw(idx), 64'(done_words));
    check($sformatf("d%0d_frame_done", idx), 64'(fdone_cnt[idx] - fd0), do_rst ? 64'h0 : 64'h1);
`endif
  endtask

  initial begin
    int nw;
    rst = 1'b1;
    sck = 3'b010;
    ssel = 3'b111;
    mosi = '0;
    svalid = '0;
    sw0 = '0; sw1 = '0; sw2 = '0;
    for (int i = 0; i < 3; i++) begin
      m_full[i] = 1'b0;
      m_hold[i] = '0;
      last_rx[i] = '0;
    end
    clear_plan();
    repeat (4) @(posedge fastclk);
    @(negedge fastclk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("d%0d_reset_miso", i), {63'h0, miso[i]}, 64'h0);
      check($sformatf("d%0d_reset_rword", i), rw(i), 64'h0);
      check($sformatf("d%0d_reset_valid", i), {63'h0, rv[i]}, 64'h0);
      check($sformatf("d%0d_reset_ready", i), {63'h0, rdy[i]}, 64'h1);
      check($sformatf("d%0d_reset_busy", i), {63'h0, bsy[i]}, 64'h0);
    end
    rst = 1'b0;
    repeat (5) @(negedge fastclk);

    // Single-word exchange in mode 0 and mode 3
    for (int i = 0; i < 2; i++) begin
      clear_plan();
      push(i, 64'hDEADBEEF);
      tx_w[0] = 64'h12345678;
      run_frame(i, 1, 0, 1'b0);
    end

    // Three-word frame with refills after each reload
    clear_plan();
    push(0, 64'hA1);
    tx_w[0] = 64'h0BADF00D; tx_w[1] = 64'h55AA33CC; tx_w[2] = 64'hFEDCBA98;
    rf_en[0] = 1'b1; rf_w[0] = 64'hB2;
    rf_en[1] = 1'b1; rf_w[1] = 64'hC3;
    run_frame(0, 3, 0, 1'b0);

    // Empty holding register at the second-word reload
    clear_plan();
    push(0, 64'h13572468);
    tx_w[0] = 64'hCAFEBABE; tx_w[1] = 64'h01234567;
    run_frame(0, 2, 0, 1'b0);
    check("d0_ready_idle", {63'h0, rdy[0]}, 64'h1);

    // SSEL raised after 17 bits; refilled word must survive to the next frame
    clear_plan();
    push(0, 64'h11112222);
    tx_w[0] = 64'h89ABCDEF;
    rf_en[0] = 1'b1; rf_w[0] = 64'h77665544;
    run_frame(0, 1, 17, 1'b0);
    clear_plan();
    tx_w[0] = 64'h2468ACE0;
    run_frame(0, 1, 0, 1'b0);

    // Reset in the middle of an 8-bit word, then a clean frame
    clear_plan();
    push(2, 64'h3C);
    tx_w[0] = 64'h96;
    run_frame(2, 1, 4, 1'b1);
    clear_plan();
    push(2, 64'h5A);
    tx_w[0] = 64'hA5;
    run_frame(2, 1, 0, 1'b0);

    // Randomised multi-word frames on every instance
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) begin
        clear_plan();
        nw = $urandom_range(1, 4);
        for (int k = 0; k < nw; k++) begin
          tx_w[k]  = {$urandom, $urandom};
          rf_w[k]  = {$urandom, $urandom};
          rf_en[k] = (k < nw - 1) && ($urandom_range(0, 1) == 1);
        end
        if (!m_full[i] && $urandom_range(0, 1) == 1) push(i, {$urandom, $urandom});
        run_frame(i, nw, 0, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
